// File: rtl/crc_pkg.sv
// Shared definitions for the bit-serial CRC engine.
// Contents:
//   crc_state_e  - engine state encoding
//   CRC8_MAXIM, CRC16_ARC, CRC32 - preset polynomials, reflected (LSB-first) form
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    TRANSMIT,
    REPORT
  } crc_state_e;

  localparam logic [7:0]  CRC8_MAXIM = 8'h8C;
  localparam logic [15:0] CRC16_ARC  = 16'hA001;
  localparam logic [31:0] CRC32      = 32'hEDB88320;

endpackage

// File: rtl/crc_lfsr_step.sv
// One Galois right-shift step of a reflected CRC register.
// Ports:
//   i_crc  - current register value
//   i_data - incoming serial bit
//   o_crc  - register value after shifting in i_data
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC8_MAXIM)
) (
  input  logic [CRC_W-1:0] i_crc,
  input  logic             i_data,
  output logic [CRC_W-1:0] o_crc
);

  logic w_fb;

  always_comb begin
    w_fb  = i_data ^ i_crc[0];
    o_crc = (i_crc >> 1) ^ (w_fb ? POLY : '0);
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Parametrised bit-serial CRC engine. Generate mode appends CRC_W CRC bits after the
// frame; check mode folds the received trailing CRC in and reports a one-cycle verdict.
// Ports:
//   CLK    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   DATA   - serial frame bit, LSB first
//   Active - frame-in-progress qualifier
//   Mode   - 0 = generate, 1 = check; latched at frame start
//   CRC    - serial CRC bit, LSB first (0 when Valid=0)
//   Valid  - CRC is meaningful
//   Done   - one-cycle end-of-frame pulse
//   Crc_ok - check verdict, only meaningful with Done in check mode
//   Busy   - state is not IDLE
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_MAXIM),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic DATA,
  input  logic Active,
  input  logic Mode,
  output logic CRC,
  output logic Valid,
  output logic Done,
  output logic Crc_ok,
  output logic Busy
);

  localparam int unsigned     CntW     = $clog2(CRC_W + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(CRC_W - 1);
  localparam logic [CntW-1:0] PenulBit = CntW'(CRC_W - 2);

  crc_state_e       r_state;
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] r_shift;
  logic [CntW-1:0]  r_cnt;
  logic             r_mode;
  logic             r_crc_bit;
  logic             r_valid;
  logic             r_done;
  logic             r_ok;
  logic             r_busy;

  logic [CRC_W-1:0] w_step;
  logic [CRC_W-1:0] w_tx;

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .i_crc  (r_crc),
    .i_data (DATA),
    .o_crc  (w_step)
  );

  assign w_tx = r_crc ^ XOR_OUT;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_crc     <= INIT;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_crc_bit <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_crc   <= INIT;
          r_shift <= '0;
          r_cnt   <= '0;
          if (Active) begin
            // The bit sampled on the start edge is frame bit 0; r_crc holds INIT here.
            r_state <= RECEIVE;
            r_mode  <= Mode;
            r_crc   <= w_step;
            r_busy  <= 1'b1;
          end
        end
        RECEIVE: begin
          if (Active) begin
            r_crc <= w_step;
          end else if (!r_mode) begin
            // Bit 0 goes straight to the output; the shifter holds bits 1..CRC_W-1.
            r_state   <= TRANSMIT;
            r_crc_bit <= w_tx[0];
            r_shift   <= w_tx >> 1;
            r_cnt     <= '0;
            r_valid   <= 1'b1;
            r_done    <= 1'b0;
          end else begin
            r_state <= REPORT;
            r_done  <= 1'b1;
            r_ok    <= (r_crc == RESIDUE);
          end
        end
        TRANSMIT: begin
          if (r_cnt == LastBit) begin
            r_state   <= IDLE;
            r_crc     <= INIT;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_crc_bit <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            r_cnt     <= r_cnt + CntW'(1);
            r_crc_bit <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_done    <= (r_cnt == PenulBit);
          end
        end
        REPORT: begin
          r_state <= IDLE;
          r_crc   <= INIT;
          r_done  <= 1'b0;
          r_ok    <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_crc   <= INIT;
        end
      endcase
    end
  end

  assign CRC    = r_crc_bit;
  assign Valid  = r_valid;
  assign Done   = r_done;
  assign Crc_ok = r_ok;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench: an 8-bit (defaults) and a 16-bit (CRC-16/ARC) engine share stimulus.
// A frame-level model computes CRCs by polynomial long division and is compared every cycle.
module tb_crc_serial_engine;

  localparam int MaxBits = 256;

  logic CLK = 1'b0;
  logic rst_n, DATA, Active, Mode;
  logic crc8, valid8, done8, ok8, busy8;
  logic crc16, valid16, done16, ok16, busy16;

  always #5 CLK = ~CLK;

  crc_serial_engine u_dut8 (
    .CLK(CLK), .rst_n(rst_n), .DATA(DATA), .Active(Active), .Mode(Mode),
    .CRC(crc8), .Valid(valid8), .Done(done8), .Crc_ok(ok8), .Busy(busy8)
  );

  crc_serial_engine #(.CRC_W(16), .POLY(16'hA001)) u_dut16 (
    .CLK(CLK), .rst_n(rst_n), .DATA(DATA), .Active(Active), .Mode(Mode),
    .CRC(crc16), .Valid(valid16), .Done(done16), .Crc_ok(ok16), .Busy(busy16)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of msg(x)*x^w mod P(x), msg in transmission order, returned reflected.
  function automatic logic [31:0] crc_div(input bit msg[0:MaxBits-1], input int n,
                                          input int w, input logic [31:0] p);
    bit a[0:MaxBits+31];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < MaxBits + 32; i++) a[i] = 1'b0;
    for (int i = 0; i < n; i++) a[i] = msg[i];
    for (int i = 0; i < n; i++)
      if (a[i]) for (int k = 0; k < w; k++) a[i+1+k] ^= p[k];
    for (int j = 0; j < w; j++) r[j] = a[n+j];
    return r;
  endfunction

  // ---------------- frame-level model, index 0 = 8-bit, 1 = 16-bit ----------------
  int          wid [2] = '{8, 16};
  logic [31:0] pol [2] = '{32'h8C, 32'hA001};
  int          ph [2];      // 0 idle, 1 collecting, 2 emitting, 3 verdict
  bit          mmode [2];
  int          nb [2];
  bit          mbits [2][0:MaxBits-1];
  logic [31:0] txv [2];
  int          txi [2];
  logic        e_crc [2], e_valid [2], e_done [2], e_ok [2], e_busy [2];

  task automatic model_clear(input int m);
    e_crc[m] = 0; e_valid[m] = 0; e_done[m] = 0; e_ok[m] = 0; e_busy[m] = 0;
  endtask

  task automatic model_step(input int m);
    bit tmp[0:MaxBits-1];
    logic [31:0] rem;
    for (int i = 0; i < MaxBits; i++) tmp[i] = mbits[m][i];
    case (ph[m])
      0: begin
        model_clear(m);
        if (Active) begin
          ph[m] = 1; mmode[m] = Mode; nb[m] = 1; mbits[m][0] = DATA; e_busy[m] = 1;
        end
      end
      1: begin
        if (Active) begin
          if (nb[m] < MaxBits) begin mbits[m][nb[m]] = DATA; nb[m]++; end
        end else begin
          rem = crc_div(tmp, nb[m], wid[m], pol[m]);
          if (!mmode[m]) begin
            ph[m] = 2; txv[m] = rem; txi[m] = 0;
            e_crc[m] = rem[0]; e_valid[m] = 1; e_done[m] = 0;
          end else begin
            ph[m] = 3; e_done[m] = 1; e_ok[m] = (rem == 0);
          end
        end
      end
      2: begin
        if (txi[m] == wid[m] - 1) begin
          ph[m] = 0; model_clear(m);
        end else begin
          txi[m]++;
          e_crc[m] = txv[m][txi[m]];
          e_done[m] = (txi[m] == wid[m] - 1);
        end
      end
      default: begin
        ph[m] = 0; model_clear(m);
      end
    endcase
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin ph[m] = 0; nb[m] = 0; model_clear(m); end
    forever begin
      @(posedge CLK or negedge rst_n);
      if (!rst_n) begin
        for (int m = 0; m < 2; m++) begin ph[m] = 0; model_clear(m); end
      end else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- per-cycle compare and capture ----------------
  bit cap0[$];
  bit cap1[$];
  int valid_cnt0, done_cnt0, done_cnt1, done_at0;
  logic last_ok0;

  initial begin
    forever begin
      @(negedge CLK);
      chk("crc8",    32'(crc8),    32'(e_crc[0]));
      chk("valid8",  32'(valid8),  32'(e_valid[0]));
      chk("done8",   32'(done8),   32'(e_done[0]));
      chk("ok8",     32'(ok8),     32'(e_ok[0]));
      chk("busy8",   32'(busy8),   32'(e_busy[0]));
      chk("crc16",   32'(crc16),   32'(e_crc[1]));
      chk("valid16", 32'(valid16), 32'(e_valid[1]));
      chk("done16",  32'(done16),  32'(e_done[1]));
      chk("ok16",    32'(ok16),    32'(e_ok[1]));
      chk("busy16",  32'(busy16),  32'(e_busy[1]));
      if (valid8) begin cap0.push_back(crc8); valid_cnt0++; end
      if (valid16) cap1.push_back(crc16);
      if (done8) begin done_cnt0++; last_ok0 = ok8; if (valid8) done_at0 = cap0.size(); end
      if (done16) done_cnt1++;
    end
  end

  // ---------------- stimulus ----------------
  bit stim[$];

  task automatic clear_caps();
    cap0.delete(); cap1.delete();
    valid_cnt0 = 0; done_cnt0 = 0; done_cnt1 = 0; done_at0 = 0; last_ok0 = 0;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) stim.push_back(b[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic send_bits(input bit mode);
    Mode = mode;
    for (int i = 0; i < stim.size(); i++) begin
      Active = 1'b1; DATA = stim[i];
      @(posedge CLK); #2;
    end
  endtask

  task automatic send(input bit mode);
    send_bits(mode);
    Active = 1'b0; DATA = 1'b0;
  endtask

  function automatic logic [31:0] pack0();
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < cap0.size() && j < 32; j++) v[j] = cap0[j];
    return v;
  endfunction

  function automatic logic [31:0] pack1();
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < cap1.size() && j < 32; j++) v[j] = cap1[j];
    return v;
  endfunction

  initial begin
    bit pin[0:MaxBits-1];
    logic [7:0] pin_b;
    rst_n = 1'b0; Active = 1'b0; DATA = 1'b0; Mode = 1'b0;
    stim = {};

    // Pin the model: 0x01 -> 0x5E, and 0x01,0x5E leaves a zero remainder.
    for (int i = 0; i < MaxBits; i++) pin[i] = 1'b0;
    pin[0] = 1'b1;
    chk("model_pin_01", crc_div(pin, 8, 8, 32'h8C), 32'h5E);
    pin_b = 8'h5E;
    for (int i = 0; i < 8; i++) pin[8+i] = pin_b[i];
    chk("model_pin_residue", crc_div(pin, 16, 8, 32'h8C), 32'h0);

    idle(2);
    chk("reset_crc",   32'(crc8),   0);
    chk("reset_valid", 32'(valid8), 0);
    chk("reset_done",  32'(done8),  0);
    chk("reset_ok",    32'(ok8),    0);
    chk("reset_busy",  32'(busy8),  0);
    rst_n = 1'b1;
    idle(2);

    // Generate 0x01
    clear_caps(); stim = {}; add_byte(8'h01);
    send(1'b0); idle(20);
    chk("gen01_len",     32'(cap0.size()), 8);
    chk("gen01_crc",     pack0(), 32'h5E);
    chk("gen01_validn",  32'(valid_cnt0), 8);
    chk("gen01_donen",   32'(done_cnt0), 1);
    chk("gen01_done_at", 32'(done_at0), 8);

    // Generate "123456789"
    clear_caps(); stim = {};
    add_byte(8'h31); add_byte(8'h32); add_byte(8'h33); add_byte(8'h34); add_byte(8'h35);
    add_byte(8'h36); add_byte(8'h37); add_byte(8'h38); add_byte(8'h39);
    send(1'b0); idle(24);
    chk("check8_len",  32'(cap0.size()), 8);
    chk("check8_crc",  pack0(), 32'hA1);
    chk("check16_len", 32'(cap1.size()), 16);
    chk("check16_crc", pack1(), 32'hBB3D);

    // Check mode, good frame
    clear_caps(); stim = {}; add_byte(8'h01); add_byte(8'h5E);
    send(1'b1); idle(4);
    chk("chk_good_done", 32'(done_cnt0), 1);
    chk("chk_good_ok",   32'(last_ok0), 1);

    // Check mode, bit 3 flipped
    clear_caps(); stim[3] = ~stim[3];
    send(1'b1); idle(4);
    chk("chk_bad_done", 32'(done_cnt0), 1);
    chk("chk_bad_ok",   32'(last_ok0), 0);

    // Reset in RECEIVE after 5 bits
    clear_caps(); stim = {}; add_byte(8'h01);
    Mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Active = 1'b1; DATA = stim[i]; @(posedge CLK); #2;
    end
    rst_n = 1'b0; #1;
    chk("rstrx_busy",  32'(busy8),  0);
    chk("rstrx_valid", 32'(valid8), 0);
    chk("rstrx_done",  32'(done8),  0);
    chk("rstrx_crc",   32'(crc8),   0);
    chk("rstrx_ok",    32'(ok8),    0);
    Active = 1'b0; DATA = 1'b0;
    idle(2); rst_n = 1'b1; idle(2);
    chk("rstrx_no_done", 32'(done_cnt0), 0);
    clear_caps();
    send(1'b0); idle(20);
    chk("rstrx_new_crc", pack0(), 32'h5E);

    // Reset during TRANSMIT bit 3
    clear_caps();
    send(1'b0);
    @(posedge CLK); #2;            // edge E: bit 0 presented
    idle(3);                       // edge E+3: bit 3 presented
    chk("rsttx_valid_before", 32'(valid8), 1);
    rst_n = 1'b0; #1;
    chk("rsttx_valid_after", 32'(valid8), 0);
    chk("rsttx_crc_after",   32'(crc8),   0);
    idle(2); rst_n = 1'b1; idle(20);
    chk("rsttx_cap_len",  32'(cap0.size()), 3);
    chk("rsttx_cap_bits", pack0(), 32'h6);
    chk("rsttx_no_done",  32'(done_cnt0), 0);

    // Back-to-back generate frames, Active held high through TRANSMIT
    clear_caps();
    send(1'b0);
    @(posedge CLK); #2;            // edge E
    Active = 1'b1; DATA = 1'b1;
    idle(8);                       // edges E+1..E+8, all still in TRANSMIT
    send(1'b0);                    // first bit sampled at E+9
    idle(24);
    chk("b2b_len",   32'(cap0.size()), 16);
    chk("b2b_crc",   pack0(), 32'h5E5E);
    chk("b2b_donen", 32'(done_cnt0), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised bit-serial CRC engine, successor to the fixed 8-bit serial CRC generator in the LPCS link path. A frame arrives one bit per clock while `Active` is high. In generate mode the block appends the CRC serially, exactly `CRC_W` bits. In check mode it folds a received trailing CRC into the register and reports pass/fail through a one-cycle residue verdict. It sits between the bit-level serialiser and the framing logic, one instance per link direction.

## Interface
- `CRC_W`, 8: CRC width in bits, 4..32.
- `POLY`, 8'h8C: polynomial in reflected (LSB-first) form, `CRC_W` bits; the default is x^8+x^5+x^4+1.
- `INIT`, 0: register value loaded in IDLE.
- `XOR_OUT`, 0: XORed onto the register before transmission.
- `RESIDUE`, 0: register value that signals a good frame in check mode.
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `DATA`  in  1  serial frame bit, LSB first; sampled when `Active`=1 in IDLE or RECEIVE.
- `Active`  in  1  frame-in-progress qualifier.
- `Mode`  in  1  0 = generate, 1 = check; sampled on the IDLE→RECEIVE edge and held for the frame.
- `CRC`  out  1  serial CRC bit, LSB first.
- `Valid`  out  1  `CRC` is meaningful.
- `Done`  out  1  one-cycle end-of-frame pulse.
- `Crc_ok`  out  1  check verdict; meaningful while `Done`=1 in check mode, otherwise 0.
- `Busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: register = `INIT`.
  - RECEIVE: shift one bit per cycle.
  - TRANSMIT: generate mode only.
  - REPORT: check mode only, one cycle.
- Galois right-shift step: `fb = DATA ^ r[0]`; `r_next = (r >> 1) ^ (fb ? POLY : 0)`.
- Transitions:
  - IDLE & `Active` → RECEIVE. The `DATA` sampled on this same edge is frame bit 0 and is shifted.
  - RECEIVE & `Active` → RECEIVE, shifting `DATA`.
  - RECEIVE & !`Active`, generate mode → TRANSMIT. `DATA` is not shifted. The output shift register is loaded with `r ^ XOR_OUT`.
  - RECEIVE & !`Active`, check mode → REPORT. `Crc_ok` is set to (`r == RESIDUE`) and `Done` is set to 1.
  - TRANSMIT: each cycle presents one bit on `CRC`, LSB first. The bit counter runs 0..`CRC_W`-1. After bit `CRC_W`-1 the block returns to IDLE. Exactly `CRC_W` bits are emitted.
  - REPORT → IDLE unconditionally.
- `Active` and `DATA` are ignored in TRANSMIT and REPORT. A frame start requires `Active` sampled high while in IDLE.
- On entry to IDLE the register reloads `INIT`. The output shift register and counter clear.
- Reset, including mid-frame, forces IDLE, register = `INIT`, and all outputs to 0. A partial frame is discarded with no `Done`.
- Counter width is `$clog2(CRC_W+1)`; it does not wrap within a frame.

## Timing
- Reset values: `CRC`=0, `Valid`=0, `Done`=0, `Crc_ok`=0, `Busy`=0.
- All outputs are registered; there are no combinational input→output paths.
- Let E be the edge at which `Active`=0 is sampled in RECEIVE.
- Generate mode:
  - Bit i of the CRC is on `CRC` with `Valid`=1 during the cycle after edge E+i, for i = 0..`CRC_W`-1.
  - `Done`=1 coincides with bit `CRC_W`-1.
  - `Valid` and `Done` drop after edge E+`CRC_W`.
- Check mode: `Done`=1 and `Crc_ok` are valid for exactly the one cycle after edge E.
- Back-to-back frames: the earliest next frame-start edge is E+`CRC_W`+1 (generate) or E+2 (check).
- `CRC` is 0 whenever `Valid`=0.

## Structure
- Shared package `crc_pkg`:
  - state enum {IDLE, RECEIVE, TRANSMIT, REPORT}.
  - Preset polynomial localparams: CRC8_MAXIM 8'h8C, CRC16_ARC 16'hA001, CRC32 32'hEDB88320.
- Sub-module `crc_lfsr_step`: combinational Galois step parametrised by `CRC_W` and `POLY`. The FSM, counter, output shifter and check compare stay in the top level.

## Test plan
- Default parameters, generate mode, single byte 0x01 (8 bits, LSB first) → `CRC` emits 0x5E LSB first (0,1,1,1,1,0,1,0). `Valid` is high for exactly 8 cycles and `Done` coincides with the 8th bit.
- Default parameters, generate mode, ASCII "123456789" (72 bits) → emitted CRC is 0xA1. Then, with `CRC_W`=16 and `POLY`=16'hA001, the same input → 0xBB3D emitted in 16 bits.
- Check mode, default parameters:
  - Stream 0x01 followed by 0x5E (16 bits) → one-cycle `Done`=1 with `Crc_ok`=1.
  - The same stream with bit 3 flipped → `Done`=1 with `Crc_ok`=0.
- Reset asserted in RECEIVE after 5 bits, then a new 0x01 frame → all outputs 0 during reset, no `Done` for the aborted frame, and the new frame yields 0x5E. Repeat the reset during TRANSMIT bit 3: `Valid` drops immediately.
- Two generate frames back-to-back, with `Active` reasserted at the earliest legal edge and also held high throughout TRANSMIT → `Active` during TRANSMIT is ignored, the second frame starts only from IDLE, and both CRCs are correct.
